fpr_file_sb: RTL and testbench
==============================

# fpr_file_sb

Parametrised floating-point register file with two registered read ports, one write port, same-cycle write-through bypass and a per-register busy scoreboard. It sits between decode and the FP execute/writeback stages. Decode issues a destination register when an instruction is dispatched, and writeback clears that register's busy bit. Each read returns data together with a busy flag, so decode can stall on RAW hazards against multi-cycle FP ops.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- ZERO_REG, 0, 1 = register 0 always reads 0, never busy, writes and issues to it ignored

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- rs  in  ADDR_W  read address, port A
- rt  in  ADDR_W  read address, port B; also write address when rdst=0
- rd  in  ADDR_W  write address when rdst=1
- rdst  in  1  write-address select: 0 = rt, 1 = rd
- reg_wr  in  1  write enable; busW written to the selected address
- busW  in  DATA_W  write data
- iss_valid  in  1  mark iss_addr busy (destination of a dispatched op)
- iss_addr  in  ADDR_W  register to mark busy
- busA  out  DATA_W  registered read data, port A
- busB  out  DATA_W  registered read data, port B
- busy_a  out  1  registered busy flag for rs
- busy_b  out  1  registered busy flag for rt
- stall  out  1  busy_a | busy_b, combinational from the registered flags
- n_busy  out  ADDR_W+1  count of busy registers, registered

## Operation
- Write address: wa = rdst ? rd : rt, evaluated in the same cycle as reg_wr.
- Storage: 2**ADDR_W x DATA_W array plus a busy vector of the same depth.
- Write: on a clk edge with reg_wr=1 and reset=0, busW is written to regFile[wa] and busy[wa] is cleared.
  - With ZERO_REG=1 and wa=0, no effect.
- Issue: on a clk edge with iss_valid=1, busy[iss_addr] is set.
  - With ZERO_REG=1 and iss_addr=0, ignored.
- Simultaneous write and issue to the same address in one cycle: data is written and busy ends at 1 (issue wins; a new producer is in flight).
- Read ports: on every clk edge, busA/busy_a are loaded from rs and busB/busy_b from rt.
- Bypass: if reg_wr=1 and wa equals a read address in the same cycle, that port loads busW and busy=0. This applies unless a same-cycle issue also targets that address, in which case busy=1 and data=busW.
- ZERO_REG=1, read address 0: data 0, busy 0.
- n_busy: tracks the number of set busy bits.
  - Increments on a set of a clear bit; decrements on a clear of a set bit.
  - Unchanged on a redundant set/clear or a same-address write+issue to an already-busy register.
  - Never exceeds 2**ADDR_W and never underflows.
- A write to a non-busy register is legal: data updated, busy stays 0.

## Timing
- Read latency is 1 cycle: address at edge t, data/busy valid after edge t, stable until edge t+1.
- A write at edge t is visible through the array to reads sampled at edge t+1. Reads sampled at edge t see it via the bypass.
- An issue at edge t makes busy visible to reads sampled at edge t. The busy output is valid after that edge; the same-cycle set is included in the bypass.
- Reset (synchronous, active-high): on an edge with reset=1:
  - all registers = 0, all busy = 0, n_busy = 0;
  - busA = busB = 0, busy_a = busy_b = 0, stall = 0;
  - reg_wr and iss_valid in that cycle are ignored.
- Reset asserted mid-operation discards all pending busy state. Writebacks arriving after reset deassertion are treated as ordinary writes.
- No combinational path from inputs to busA/busB/busy_a/busy_b/n_busy. stall depends only on registered flags.

## Test plan
- Reset then read all addresses: busA=busB=0, busy_a=busy_b=0, n_busy=0 for every rs/rt.
- rdst=1, rd=7, busW=0x3F800000, reg_wr=1; next cycle rs=7: busA=0x3F800000. Repeat with rdst=0, rt=9: written to reg 9, not reg 7.
- Same-cycle bypass: reg_wr=1, rdst=1, rd=4, busW=0x40490FDB, rs=4: busA=0x40490FDB after that same edge.
- Scoreboard:
  - iss_valid, iss_addr=3: n_busy=1, next read rs=3 gives busy_a=1, stall=1.
  - Write reg 3: busy_a=0, n_busy=0.
  - Issue and write reg 3 in the same cycle: busy stays 1, n_busy=1.
- ZERO_REG=1: write 0xDEADBEEF to reg 0 and issue reg 0, then read rs=0: busA=0, busy_a=0, n_busy unchanged.
- Issue regs 1..31 plus 0 with ZERO_REG=0: n_busy=32. Assert reset for one cycle: n_busy=0, all outputs 0, the write and issue presented during reset have no effect.

Source files
------------

// File: rtl/fpr_file_sb.sv
// FP register file: two registered read ports, one write port,
// write-through bypass and a per-register busy scoreboard.
module fpr_file_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  input  logic [ADDR_W-1:0] rd,
  input  logic              rdst,
  input  logic              reg_wr,
  input  logic [DATA_W-1:0] busW,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_addr,
  output logic [DATA_W-1:0] busA,
  output logic [DATA_W-1:0] busB,
  output logic              busy_a,
  output logic              busy_b,
  output logic              stall,
  output logic [ADDR_W:0]   n_busy
);
  localparam int DEPTH = 2**ADDR_W;
  localparam bit ZR    = (ZERO_REG != 0);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic              ba_q, ba_d, bb_q, bb_d;

  logic [ADDR_W-1:0] wa;
  logic              wr_en, is_en, inc, dec;

  assign wa    = rdst ? rd : rt;
  assign wr_en = reg_wr && !(ZR && wa == '0);
  assign is_en = iss_valid && !(ZR && iss_addr == '0);

  // Issue wins over a same-address write, so no decrement then.
  assign inc = is_en && !busy_q[iss_addr];
  assign dec = wr_en && busy_q[wa] && !(is_en && iss_addr == wa);

  always_comb begin
    busy_d = busy_q;
    if (wr_en) busy_d[wa] = 1'b0;
    if (is_en) busy_d[iss_addr] = 1'b1;

    cnt_d = cnt_q + {{ADDR_W{1'b0}}, inc}
                  - {{ADDR_W{1'b0}}, dec};

    a_d  = (wr_en && wa == rs) ? busW : mem_q[rs];
    ba_d = busy_d[rs];
    if (ZR && rs == '0) begin
      a_d  = '0;
      ba_d = 1'b0;
    end

    b_d  = (wr_en && wa == rt) ? busW : mem_q[rt];
    bb_d = busy_d[rt];
    if (ZR && rt == '0) begin
      b_d  = '0;
      bb_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      busy_q <= '0;
      cnt_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      ba_q   <= 1'b0;
      bb_q   <= 1'b0;
    end else begin
      if (wr_en) mem_q[wa] <= busW;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      a_q    <= a_d;
      b_q    <= b_d;
      ba_q   <= ba_d;
      bb_q   <= bb_d;
    end
  end

  assign busA   = a_q;
  assign busB   = b_q;
  assign busy_a = ba_q;
  assign busy_b = bb_q;
  assign stall  = ba_q | bb_q;
  assign n_busy = cnt_q;

endmodule

// File: tb/tb_fpr_file_sb.sv
// Bench for fpr_file_sb: ZERO_REG=0 and ZERO_REG=1 instances
// driven in parallel and compared to an array-based model.
module tb_fpr_file_sb;
  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rs, rt, rd, iss_addr;
  logic        rdst, reg_wr, iss_valid;
  logic [31:0] busW;

  logic [31:0] busA0, busB0, busA1, busB1;
  logic        ba0, bb0, st0, ba1, bb1, st1;
  logic [5:0]  nb0, nb1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fpr_file_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0)) u0 (
    .clk(clk), .reset(reset), .rs(rs), .rt(rt), .rd(rd),
    .rdst(rdst), .reg_wr(reg_wr), .busW(busW),
    .iss_valid(iss_valid), .iss_addr(iss_addr),
    .busA(busA0), .busB(busB0), .busy_a(ba0), .busy_b(bb0),
    .stall(st0), .n_busy(nb0)
  );

  fpr_file_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) u1 (
    .clk(clk), .reset(reset), .rs(rs), .rt(rt), .rd(rd),
    .rdst(rdst), .reg_wr(reg_wr), .busW(busW),
    .iss_valid(iss_valid), .iss_addr(iss_addr),
    .busA(busA1), .busB(busB1), .busy_a(ba1), .busy_b(bb1),
    .stall(st1), .n_busy(nb1)
  );

  // Reference state: index 0 models ZERO_REG=0, index 1 ZERO_REG=1
  logic [31:0] mmem  [2][32];
  bit          mbusy [2][32];
  logic [31:0] eA [2], eB [2];
  bit          eba [2], ebb [2];
  int          en [2];

  task automatic model(input int z);
    int wa;
    bit wv, iv;
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        mmem[z][i]  = 0;
        mbusy[z][i] = 0;
      end
      eA[z] = 0; eB[z] = 0; eba[z] = 0; ebb[z] = 0; en[z] = 0;
      return;
    end
    wa = rdst ? int'(rd) : int'(rt);
    wv = reg_wr && !(z == 1 && wa == 0);
    iv = iss_valid && !(z == 1 && iss_addr == 0);
    if (wv) begin
      mmem[z][wa]  = busW;
      mbusy[z][wa] = 0;
    end
    if (iv) mbusy[z][iss_addr] = 1;
    if (z == 1 && rs == 0) begin
      eA[z] = 0; eba[z] = 0;
    end else begin
      eA[z] = mmem[z][rs]; eba[z] = mbusy[z][rs];
    end
    if (z == 1 && rt == 0) begin
      eB[z] = 0; ebb[z] = 0;
    end else begin
      eB[z] = mmem[z][rt]; ebb[z] = mbusy[z][rt];
    end
    en[z] = 0;
    for (int i = 0; i < 32; i++) en[z] += int'(mbusy[z][i]);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("u0.busA",   64'(busA0), 64'(eA[0]));
    chk("u0.busB",   64'(busB0), 64'(eB[0]));
    chk("u0.busy_a", 64'(ba0),   64'(eba[0]));
    chk("u0.busy_b", 64'(bb0),   64'(ebb[0]));
    chk("u0.stall",  64'(st0),   64'(eba[0] | ebb[0]));
    chk("u0.n_busy", 64'(nb0),   64'(en[0]));
    chk("u1.busA",   64'(busA1), 64'(eA[1]));
    chk("u1.busB",   64'(busB1), 64'(eB[1]));
    chk("u1.busy_a", 64'(ba1),   64'(eba[1]));
    chk("u1.busy_b", 64'(bb1),   64'(ebb[1]));
    chk("u1.stall",  64'(st1),   64'(eba[1] | ebb[1]));
    chk("u1.n_busy", 64'(nb1),   64'(en[1]));
  endtask

  task automatic step();
    @(posedge clk);
    model(0);
    model(1);
    #1;
    check_all();
  endtask

  task automatic drive(input logic r, input int a, input int b,
                       input int d, input logic sel, input logic w,
                       input logic [31:0] data, input logic iv,
                       input int ia);
    reset     = r;
    rs        = 5'(a);
    rt        = 5'(b);
    rd        = 5'(d);
    rdst      = sel;
    reg_wr    = w;
    busW      = data;
    iss_valid = iv;
    iss_addr  = 5'(ia);
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 1, 32'hAAAA5555, 1, 2);
    step();
    step();

    for (int i = 0; i < 32; i++) begin
      drive(0, i, 31 - i, 0, 0, 0, 0, 0, 0);
      step();
    end

    drive(0, 0, 0, 7, 1, 1, 32'h3F800000, 0, 0);
    step();
    drive(0, 7, 0, 0, 0, 0, 0, 0, 0);
    step();
    chk("rd7_write", 64'(busA0), 64'h3F800000);

    drive(0, 0, 9, 7, 0, 1, 32'h12345678, 0, 0);
    step();
    drive(0, 7, 9, 0, 0, 0, 0, 0, 0);
    step();
    chk("rt9_keeps7", 64'(busA0), 64'h3F800000);
    chk("rt9_write",  64'(busB0), 64'h12345678);

    drive(0, 4, 0, 4, 1, 1, 32'h40490FDB, 0, 0);
    step();
    chk("bypass", 64'(busA0), 64'h40490FDB);

    drive(0, 0, 0, 0, 0, 0, 0, 1, 3);
    step();
    chk("iss3_cnt", 64'(nb0), 64'd1);
    drive(0, 3, 0, 0, 0, 0, 0, 0, 0);
    step();
    chk("iss3_busy",  64'(ba0), 64'd1);
    chk("iss3_stall", 64'(st0), 64'd1);

    drive(0, 3, 0, 3, 1, 1, 32'h11111111, 0, 0);
    step();
    chk("wb3_busy", 64'(ba0), 64'd0);
    chk("wb3_cnt",  64'(nb0), 64'd0);

    drive(0, 3, 0, 3, 1, 1, 32'h22222222, 1, 3);
    step();
    chk("wbiss3_busy", 64'(ba0), 64'd1);
    chk("wbiss3_cnt",  64'(nb0), 64'd1);
    chk("wbiss3_data", 64'(busA0), 64'h22222222);

    drive(0, 0, 0, 0, 1, 1, 32'hDEADBEEF, 1, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    chk("zr_data", 64'(busA1), 64'd0);
    chk("zr_busy", 64'(ba1),   64'd0);
    chk("zr_cnt",  64'(nb1),   64'd1);

    for (int i = 1; i <= 32; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 1, i % 32);
      step();
    end
    chk("all_busy", 64'(nb0), 64'd32);

    drive(1, 5, 6, 5, 1, 1, 32'hFFFF0000, 1, 6);
    step();
    chk("rst_cnt", 64'(nb0), 64'd0);
    drive(0, 5, 6, 0, 0, 0, 0, 0, 0);
    step();
    chk("rst_wr",  64'(busA0), 64'd0);
    chk("rst_iss", 64'(bb0),   64'd0);

    for (int n = 0; n < 800; n++) begin
      int hi;
      hi = ($urandom_range(0, 3) == 0) ? 31 : 7;
      drive(($urandom_range(0, 79) == 0),
            $urandom_range(0, hi), $urandom_range(0, hi),
            $urandom_range(0, hi), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 9) < 5), $urandom,
            ($urandom_range(0, 9) < 4), $urandom_range(0, hi));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
